// File: rtl/alephminer_axi_read_master.sv
// alephminer_axi_read_master: AXI4 read master that streams a contiguous byte region to a valid/ready sink.
// Bursts are split on 4 KiB / 256-beat boundaries and issued ahead of consumption up to C_MAX_OUTSTANDING.
module alephminer_axi_read_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_XFER_SIZE_WIDTH  = C_M_AXI_ADDR_WIDTH,
    parameter int C_MAX_OUTSTANDING  = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          ctrl_start,
    output logic                          ctrl_done,
    output logic                          ctrl_busy,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
    output logic                          ctrl_rresp_err,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    output logic                          Vld_O,
    input  logic                          Rdy_I,
    output logic [C_M_AXI_DATA_WIDTH-1:0] Data_O,
    output logic                          Last_O
);
    localparam int AW          = C_M_AXI_ADDR_WIDTH;
    localparam int XW          = C_XFER_SIZE_WIDTH;
    localparam int DW_BYTES    = C_M_AXI_DATA_WIDTH / 8;
    localparam int BURST_LEN   = (4096 / DW_BYTES < 256) ? 4096 / DW_BYTES : 256;
    localparam int BURST_BYTES = DW_BYTES * BURST_LEN;
    localparam int SB          = $clog2(DW_BYTES);
    localparam int SL          = $clog2(BURST_LEN);
    localparam int OW          = $clog2(C_MAX_OUTSTANDING) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [XW-1:0] beats, bursts, bursts_left;
    logic [7:0]    final_len;
    logic [OW-1:0] outstanding;
    logic          run, start_ok, ar_hs, r_hs, rlast_hs, unused_rresp;

    assign run          = state == RUN;
    assign start_ok     = state == IDLE && ctrl_start;
    assign unused_rresp = m_axi_rresp[0];

    // ceil divisions done as shift plus remainder-nonzero so no intermediate can overflow
    assign beats  = (ctrl_xfer_size_in_bytes >> SB) + XW'(|ctrl_xfer_size_in_bytes[SB-1:0]);
    assign bursts = (beats >> SL) + XW'(|beats[SL-1:0]);

    assign m_axi_arvalid = run && bursts_left != '0 && outstanding < OW'(C_MAX_OUTSTANDING);
    assign m_axi_arlen   = !m_axi_arvalid ? 8'd0 : bursts_left == XW'(1) ? final_len : 8'(BURST_LEN - 1);
    assign m_axi_rready  = Rdy_I && run;
    assign Vld_O         = m_axi_rvalid && run;
    assign Data_O        = m_axi_rdata;
    assign Last_O        = run && m_axi_rlast && bursts_left == '0 && outstanding == OW'(1);
    assign ctrl_busy     = run;
    assign ctrl_done     = state == DONE;

    assign ar_hs    = m_axi_arvalid && m_axi_arready;
    assign r_hs     = m_axi_rvalid && m_axi_rready;
    assign rlast_hs = r_hs && m_axi_rlast;

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start_ok) state_nxt = ctrl_xfer_size_in_bytes == '0 ? DONE : RUN;
        else if (r_hs && Last_O) state_nxt = DONE;
        else if (state == DONE) state_nxt = IDLE;
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            m_axi_araddr   <= '0;
            bursts_left    <= '0;
            final_len      <= '0;
            outstanding    <= '0;
            ctrl_rresp_err <= 1'b0;
        end else begin
            if (start_ok) begin
                m_axi_araddr   <= ctrl_addr_offset & ~AW'(BURST_BYTES - 1);
                bursts_left    <= bursts;
                final_len      <= 8'((beats - XW'(1)) & XW'(BURST_LEN - 1));
                ctrl_rresp_err <= 1'b0;
            end else if (ar_hs) begin
                m_axi_araddr <= m_axi_araddr + AW'(BURST_BYTES);
                bursts_left  <= bursts_left - XW'(1);
            end
            if (r_hs && m_axi_rresp[1]) ctrl_rresp_err <= 1'b1;
            if (ar_hs != rlast_hs) outstanding <= ar_hs ? outstanding + OW'(1) : outstanding - OW'(1);
        end
    end
endmodule

// File: tb/tb_alephminer_axi_read_master.sv
// tb_alephminer_axi_read_master: directed tests of the AXI read master against a queue-based AXI slave.
// Main instance uses DW=32 with two outstanding bursts; a second DW=512 instance is driven by hand.
module tb_alephminer_axi_read_master;
    logic aclk = 1'b0;
    logic areset = 1'b0;
    always #5 aclk = ~aclk;

    logic        start = 1'b0, done, busy, err;
    logic [63:0] addr_off = '0, xfer = '0;
    logic        arvalid, arready = 1'b1;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid = 1'b0, rready, rlast = 1'b0, vld, rdy = 1'b1, last;
    logic [31:0] rdata = '0, data;
    logic [1:0]  rresp = '0;

    logic         b_start = 1'b0, b_done, b_busy, b_err;
    logic [63:0]  b_addr = '0, b_xfer = '0;
    logic         b_arvalid, b_arready = 1'b0;
    logic [63:0]  b_araddr;
    logic [7:0]   b_arlen;
    logic         b_rvalid = 1'b0, b_rready, b_rlast = 1'b0, b_vld, b_rdy = 1'b1, b_last;
    logic [511:0] b_rdata = '0, b_data;
    logic [1:0]   b_rresp = '0;

    alephminer_axi_read_master #(.C_M_AXI_DATA_WIDTH(32), .C_MAX_OUTSTANDING(2)) u_dut (
        .aclk(aclk), .areset(areset), .ctrl_start(start), .ctrl_done(done), .ctrl_busy(busy),
        .ctrl_addr_offset(addr_off), .ctrl_xfer_size_in_bytes(xfer), .ctrl_rresp_err(err),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .Vld_O(vld), .Rdy_I(rdy), .Data_O(data), .Last_O(last)
    );

    alephminer_axi_read_master #(.C_M_AXI_DATA_WIDTH(512)) u_dut512 (
        .aclk(aclk), .areset(areset), .ctrl_start(b_start), .ctrl_done(b_done), .ctrl_busy(b_busy),
        .ctrl_addr_offset(b_addr), .ctrl_xfer_size_in_bytes(b_xfer), .ctrl_rresp_err(b_err),
        .m_axi_arvalid(b_arvalid), .m_axi_arready(b_arready), .m_axi_araddr(b_araddr), .m_axi_arlen(b_arlen),
        .m_axi_rvalid(b_rvalid), .m_axi_rready(b_rready), .m_axi_rdata(b_rdata), .m_axi_rresp(b_rresp),
        .m_axi_rlast(b_rlast), .Vld_O(b_vld), .Rdy_I(b_rdy), .Data_O(b_data), .Last_O(b_last)
    );

    int total = 0, bad = 0, cyc = 0;
    logic [63:0] pend_addr[$];
    int          pend_len[$];
    int          beat = 0, rbeats = 0, outst = 0, max_outst = 0, simul_cnt = 0;
    logic [63:0] ar_addr_log[$];
    int          ar_len_log[$], ar_cyc_log[$], last_idx[$];
    logic [31:0] got[$];
    int          done_cnt = 0, done_cyc = -1, last_cyc = -2, first_rlast_cyc = -1;
    bit          r_hold = 0, rnd_rdy = 0, sync_ar = 0, ar_hs, rl_hs;
    int          err_at = -1;

    function automatic logic [31:0] pat(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE0000;
    endfunction

    // Slave and stream monitor: sample at the active edge, drive 1 ns later
    initial forever begin
        @(posedge aclk);
        cyc++;
        if (!areset) begin
            pend_addr.delete(); pend_len.delete(); beat = 0; outst = 0;
        end else begin
            ar_hs = arvalid && arready;
            rl_hs = rvalid && rready && rlast;
            if (ar_hs) begin
                ar_addr_log.push_back(araddr); ar_len_log.push_back(int'(arlen)); ar_cyc_log.push_back(cyc);
                pend_addr.push_back(araddr); pend_len.push_back(int'(arlen));
            end
            if (vld && rdy) begin
                got.push_back(data);
                if (last) begin last_idx.push_back(got.size() - 1); last_cyc = cyc; end
            end
            if (rvalid && rready) begin
                rbeats++;
                if (rlast && pend_addr.size() > 0) begin
                    if (first_rlast_cyc < 0) first_rlast_cyc = cyc;
                    void'(pend_addr.pop_front()); void'(pend_len.pop_front()); beat = 0;
                end else beat++;
            end
            if (ar_hs && rl_hs) simul_cnt++;
            outst = outst + (ar_hs ? 1 : 0) - (rl_hs ? 1 : 0);
            if (outst > max_outst) max_outst = outst;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        #1;
        if (pend_addr.size() > 0) begin
            rdata = pat(pend_addr[0] + 64'(beat * 4));
            rlast = beat == pend_len[0];
        end else begin
            rdata = '0; rlast = 1'b0;
        end
        rvalid  = !r_hold && pend_addr.size() > 0;
        rresp   = rbeats == err_at ? 2'b10 : 2'b00;
        rdy     = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        arready = sync_ar ? (pend_addr.size() == 0 || (rvalid && rlast && rdy)) : 1'b1;
    end

    task automatic clear_logs();
        ar_addr_log.delete(); ar_len_log.delete(); ar_cyc_log.delete(); got.delete(); last_idx.delete();
        done_cnt = 0; done_cyc = -1; last_cyc = -2; first_rlast_cyc = -1;
        max_outst = 0; simul_cnt = 0; rbeats = 0;
    endtask

    task automatic start_xfer(input logic [63:0] a, input logic [63:0] n);
        clear_logs();
        @(negedge aclk); addr_off = a; xfer = n; start = 1'b1;
        @(negedge aclk); start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        int n = 0;
        while (done_cnt == 0 && n < maxc) begin @(negedge aclk); n++; end
        ok = done_cnt != 0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({busy, done, err, arvalid, rready, vld, last} !== 7'b0) begin
            bad++; $display("FAIL reset_ctrl: busy=%b done=%b err=%b arvalid=%b rready=%b vld=%b last=%b, all must be 0",
                            busy, done, err, arvalid, rready, vld, last);
        end
        total++;
        if (araddr !== '0 || arlen !== '0 || {b_busy, b_done, b_arvalid} !== 3'b0) begin
            bad++; $display("FAIL reset_ar: araddr=%h arlen=%h b_busy=%b, need 0", araddr, arlen, b_busy);
        end
        @(negedge aclk); areset = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_single();
        bit ok;
        int errs = 0;
        start_xfer(64'h1000, 64'd64);
        total++;
        if (busy !== 1'b1 || arvalid !== 1'b1 || araddr !== 64'h1000 || arlen !== 8'd15) begin
            bad++; $display("FAIL single_ar: busy=%b arvalid=%b araddr=%h arlen=%0d, need 1 1 1000 15", busy, arvalid, araddr, arlen);
        end
        wait_done(200, ok);
        total++;
        if (!ok || busy !== 1'b0) begin bad++; $display("FAIL single_done: done_seen=%b busy=%b, need 1 0", ok, busy); end
        repeat (3) @(negedge aclk);
        for (int i = 0; i < got.size(); i++) if (got[i] !== pat(64'h1000 + 64'(4 * i))) errs++;
        total++;
        if (got.size() != 16 || errs != 0) begin
            bad++; $display("FAIL single_data: beats=%0d wrong=%0d, need 16 0", got.size(), errs);
        end
        total++;
        if (ar_addr_log.size() != 1 || done_cnt != 1 || last_idx.size() != 1 || last_idx[0] != 15) begin
            bad++; $display("FAIL single_count: ars=%0d dones=%0d lasts=%0d, need 1 1 1@15", ar_addr_log.size(), done_cnt, last_idx.size());
        end
        total++;
        if (done_cyc != last_cyc + 1) begin
            bad++; $display("FAIL single_done_timing: done_cyc=%0d, need %0d", done_cyc, last_cyc + 1);
        end
    endtask

    task automatic test_multi();
        bit ok;
        int errs = 0, arerrs = 0;
        start_xfer(64'h0, 64'd5000);
        wait_done(3000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL multi_done: timeout, done never seen"); end
        repeat (2) @(negedge aclk);
        for (int k = 0; k < ar_addr_log.size(); k++)
            if (ar_addr_log[k] !== 64'(1024 * k) || ar_len_log[k] != (k == 4 ? 225 : 255)) arerrs++;
        total++;
        if (ar_addr_log.size() != 5 || arerrs != 0) begin
            bad++; $display("FAIL multi_ar: ars=%0d wrong=%0d, need 5 0", ar_addr_log.size(), arerrs);
        end
        for (int i = 0; i < got.size(); i++) if (got[i] !== pat(64'(4 * i))) errs++;
        total++;
        if (got.size() != 1250 || errs != 0 || last_idx.size() != 1 || last_idx[0] != 1249) begin
            bad++; $display("FAIL multi_data: beats=%0d wrong=%0d lasts=%0d, need 1250 0 1", got.size(), errs, last_idx.size());
        end
    endtask

    task automatic test_outstanding();
        bit ok;
        r_hold = 1;
        start_xfer(64'h0, 64'd16384);
        repeat (20) @(negedge aclk);
        total++;
        if (ar_addr_log.size() != 2 || arvalid !== 1'b0) begin
            bad++; $display("FAIL outst_limit: ars=%0d arvalid=%b, need 2 0", ar_addr_log.size(), arvalid);
        end
        r_hold = 0;
        wait_done(6000, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL outst_done: timeout, done never seen"); end
        total++;
        if (ar_addr_log.size() != 16 || ar_cyc_log[2] != first_rlast_cyc + 1) begin
            bad++; $display("FAIL outst_reissue: ars=%0d, need 16 with third AR one cycle after first rlast (%0d)",
                            ar_addr_log.size(), first_rlast_cyc + 1);
        end
        total++;
        if (max_outst != 2 || got.size() != 4096 || last_idx.size() != 1 || last_idx[0] != 4095) begin
            bad++; $display("FAIL outst_stream: max_outst=%0d beats=%0d lasts=%0d, need 2 4096 1", max_outst, got.size(), last_idx.size());
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        sync_ar = 1;
        start_xfer(64'h0, 64'd2056);
        wait_done(2000, ok);
        sync_ar = 0;
        total++;
        if (!ok) begin bad++; $display("FAIL simul_done: timeout, done never seen"); end
        total++;
        if (ar_addr_log.size() != 3 || ar_len_log[2] != 1 || simul_cnt != 2 || max_outst != 1) begin
            bad++; $display("FAIL simul_ar: ars=%0d simul=%0d max_outst=%0d, need 3 2 1", ar_addr_log.size(), simul_cnt, max_outst);
        end
        total++;
        if (got.size() != 514 || last_idx.size() != 1 || last_idx[0] != 513) begin
            bad++; $display("FAIL simul_stream: beats=%0d lasts=%0d, need 514 1", got.size(), last_idx.size());
        end
    endtask

    task automatic test_backpressure_err();
        bit ok;
        int errs = 0;
        rnd_rdy = 1; err_at = 7;
        start_xfer(64'h2000, 64'd200);
        total++;
        if (arlen !== 8'd49 || araddr !== 64'h2000 || err !== 1'b0) begin
            bad++; $display("FAIL bp_ar: arlen=%0d araddr=%h err=%b, need 49 2000 0", arlen, araddr, err);
        end
        wait_done(1000, ok);
        rnd_rdy = 0; err_at = -1;
        repeat (3) @(negedge aclk);
        for (int i = 0; i < got.size(); i++) if (got[i] !== pat(64'h2000 + 64'(4 * i))) errs++;
        total++;
        if (!ok || got.size() != 50 || errs != 0 || last_idx.size() != 1 || last_idx[0] != 49) begin
            bad++; $display("FAIL bp_data: done=%b beats=%0d wrong=%0d lasts=%0d, need 1 50 0 1", ok, got.size(), errs, last_idx.size());
        end
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL bp_err_sticky: err=%b, need 1", err); end
        start_xfer(64'h5000, 64'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || arvalid !== 1'b0) begin
            bad++; $display("FAIL zero_start: done=%b busy=%b err=%b arvalid=%b, need 1 0 0 0", done, busy, err, arvalid);
        end
        repeat (3) @(negedge aclk);
        total++;
        if (done !== 1'b0 || done_cnt != 1 || ar_addr_log.size() != 0) begin
            bad++; $display("FAIL zero_after: done=%b dones=%0d ars=%0d, need 0 1 0", done, done_cnt, ar_addr_log.size());
        end
    endtask

    task automatic test_busy_start();
        bit ok;
        start_xfer(64'h0, 64'd64);
        repeat (3) @(negedge aclk);
        addr_off = 64'h3000; xfer = 64'd4; start = 1'b1;
        @(negedge aclk); start = 1'b0;
        wait_done(200, ok);
        repeat (4) @(negedge aclk);
        total++;
        if (!ok || ar_addr_log.size() != 1 || ar_addr_log[0] !== 64'h0 || got.size() != 16 || done_cnt != 1) begin
            bad++; $display("FAIL busy_start: done=%b ars=%0d beats=%0d dones=%0d, need 1 1@0 16 1", ok, ar_addr_log.size(), got.size(), done_cnt);
        end
    endtask

    task automatic test_areset();
        bit ok;
        int errs = 0;
        start_xfer(64'h0, 64'd4096);
        repeat (10) @(negedge aclk);
        #2 areset = 1'b0;
        #1;
        total++;
        if ({busy, done, err, arvalid, rready, vld, last} !== 7'b0 || araddr !== '0 || arlen !== '0) begin
            bad++; $display("FAIL areset_async: busy=%b arvalid=%b rready=%b vld=%b araddr=%h, need all 0", busy, arvalid, rready, vld, araddr);
        end
        @(negedge aclk); areset = 1'b1;
        @(negedge aclk);
        start_xfer(64'h800, 64'd64);
        wait_done(200, ok);
        repeat (2) @(negedge aclk);
        for (int i = 0; i < got.size(); i++) if (got[i] !== pat(64'h800 + 64'(4 * i))) errs++;
        total++;
        if (!ok || got.size() != 16 || errs != 0 || last_idx.size() != 1 || ar_addr_log.size() != 1) begin
            bad++; $display("FAIL areset_recover: done=%b beats=%0d wrong=%0d lasts=%0d, need 1 16 0 1", ok, got.size(), errs, last_idx.size());
        end
    endtask

    task automatic test_dw512();
        logic [511:0] word;
        word = {16{32'hDEADBEEF}};
        @(negedge aclk); b_addr = 64'h12345; b_xfer = 64'd65; b_start = 1'b1;
        @(negedge aclk); b_start = 1'b0;
        total++;
        if (b_busy !== 1'b1 || b_arvalid !== 1'b1 || b_araddr !== 64'h12000 || b_arlen !== 8'd1) begin
            bad++; $display("FAIL w512_ar: busy=%b arvalid=%b araddr=%h arlen=%0d, need 1 1 12000 1", b_busy, b_arvalid, b_araddr, b_arlen);
        end
        b_arready = 1'b1;
        @(negedge aclk); b_arready = 1'b0;
        total++;
        if (b_arvalid !== 1'b0) begin bad++; $display("FAIL w512_one_ar: arvalid=%b, need 0", b_arvalid); end
        b_rvalid = 1'b1; b_rdata = word; b_rlast = 1'b0; #1;
        total++;
        if (b_vld !== 1'b1 || b_last !== 1'b0 || b_data !== word) begin
            bad++; $display("FAIL w512_beat1: vld=%b last=%b, need 1 0 with data passed through", b_vld, b_last);
        end
        @(negedge aclk); b_rlast = 1'b1; #1;
        total++;
        if (b_last !== 1'b1) begin bad++; $display("FAIL w512_last: last=%b, need 1", b_last); end
        @(negedge aclk); b_rvalid = 1'b0; b_rlast = 1'b0;
        total++;
        if (b_done !== 1'b1 || b_busy !== 1'b0) begin bad++; $display("FAIL w512_done: done=%b busy=%b, need 1 0", b_done, b_busy); end
        b_xfer = 64'd0; b_start = 1'b1;
        @(negedge aclk); b_start = 1'b0;
        total++;
        if (b_done !== 1'b0) begin bad++; $display("FAIL w512_done_pulse: done=%b, need 0", b_done); end
        @(negedge aclk);
        total++;
        if (b_done !== 1'b0 || b_busy !== 1'b0 || b_arvalid !== 1'b0) begin
            bad++; $display("FAIL w512_zero_end: done=%b busy=%b arvalid=%b, need 0 0 0", b_done, b_busy, b_arvalid);
        end
    endtask

    task automatic test_dw512_zero();
        @(negedge aclk); b_xfer = 64'd0; b_start = 1'b1;
        @(negedge aclk); b_start = 1'b0;
        total++;
        if (b_done !== 1'b1 || b_busy !== 1'b0 || b_arvalid !== 1'b0) begin
            bad++; $display("FAIL w512_zero: done=%b busy=%b arvalid=%b, need 1 0 0", b_done, b_busy, b_arvalid);
        end
        @(negedge aclk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_outstanding();
        test_simultaneous();
        test_backpressure_err();
        test_busy_start();
        test_areset();
        test_dw512();
        test_dw512_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
